// File: rtl/muldiv_share_ctrl.sv
// muldiv_share_ctrl: round-robin arbiter and sequencer that shares one
// RV32M multiply/divide unit among NCORES cores, one operation at a time.
// Optional feature macro: MULDIV_SHARE_DIV_EN adds the radix-2 restoring
// divider and the DIV state. Without it, divide-class requests are granted
// and answered with a zero result.
module muldiv_share_ctrl #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NCORES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES-1:0]        req_valid,
    output logic [NCORES-1:0]        req_ready,
    input  logic [NCORES*WIDTH-1:0]  req_op1,
    input  logic [NCORES*WIDTH-1:0]  req_op2,
    input  logic [NCORES*3-1:0]      req_funct3,
    output logic [NCORES-1:0]        resp_valid,
    input  logic [NCORES-1:0]        resp_ready,
    output logic [WIDTH-1:0]         resp_result,
    output logic                     busy
);

    localparam int unsigned IDW  = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned CNTW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [IDW-1:0]       r_rr_ptr;
    logic [IDW-1:0]       r_id;
    logic [WIDTH-1:0]     r_op1;
    logic [WIDTH-1:0]     r_op2;
    logic [2:0]           r_funct3;
    logic [WIDTH-1:0]     r_result;
    logic [NCORES-1:0]    r_resp_valid;

    logic                 w_found;
    logic [IDW-1:0]       w_winner;
    logic [IDW:0]         w_idx;
    logic [IDW-1:0]       w_ptr_nxt;
    logic [NCORES-1:0]    w_grant_oh;
    logic [WIDTH-1:0]     w_sel_op1;
    logic [WIDTH-1:0]     w_sel_op2;
    logic [2:0]           w_sel_f3;

    logic                 w_a_signed;
    logic                 w_b_signed;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_mul_res;
    logic [WIDTH-1:0]     w_mul_out;

`ifdef MULDIV_SHARE_DIV_EN
    logic                 r_div_first;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_dvs;
    logic [CNTW-1:0]      r_cnt;
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic                 w_div_signed;
    logic                 w_div_is_rem;
    logic                 w_op1_neg;
    logic                 w_op2_neg;
    logic [WIDTH-1:0]     w_op1_mag;
    logic [WIDTH-1:0]     w_op2_mag;
    logic                 w_div_zero;
    logic                 w_div_ovf;
    logic                 w_div_special;
    logic [WIDTH-1:0]     w_special_res;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quot_nxt;
    logic                 w_div_last;
    logic [WIDTH-1:0]     w_div_res;
`endif

    // Round-robin search: first valid core at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < int'(NCORES); k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NCORES)) begin
                w_idx = w_idx - (IDW+1)'(NCORES);
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[IDW-1:0];
            end
        end
    end

    // Winner's operands and pointer successor.
    always_comb begin
        w_sel_op1 = '0;
        w_sel_op2 = '0;
        w_sel_f3  = '0;
        for (int k = 0; k < int'(NCORES); k++) begin
            if (IDW'(k) == w_winner) begin
                w_sel_op1 = req_op1[k*WIDTH +: WIDTH];
                w_sel_op2 = req_op2[k*WIDTH +: WIDTH];
                w_sel_f3  = req_funct3[k*3 +: 3];
            end
        end
        w_ptr_nxt  = (w_winner == IDW'(NCORES-1)) ? '0 : w_winner + IDW'(1);
        w_grant_oh = NCORES'(1) << w_winner;
    end

    // Grant is combinational and only offered while idle.
    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_found) begin
            req_ready = w_grant_oh;
        end
    end

    // Multiplier: sign-extend per funct3 and take the low or high half.
    always_comb begin
        w_a_signed = (r_funct3[1:0] == 2'b01) || (r_funct3[1:0] == 2'b10);
        w_b_signed = (r_funct3[1:0] == 2'b01);
        w_a_ext    = {{WIDTH{w_a_signed & r_op1[WIDTH-1]}}, r_op1};
        w_b_ext    = {{WIDTH{w_b_signed & r_op2[WIDTH-1]}}, r_op2};
        w_prod     = w_a_ext * w_b_ext;
        w_mul_res  = (r_funct3[1:0] == 2'b00) ? w_prod[WIDTH-1:0]
                                              : w_prod[2*WIDTH-1:WIDTH];
        // Only reachable with funct3[2]=1 when the divider is absent.
        w_mul_out  = r_funct3[2] ? '0 : w_mul_res;
    end

`ifdef MULDIV_SHARE_DIV_EN
    // Divider: sign handling, special cases and one restoring step.
    always_comb begin
        w_div_signed  = ~r_funct3[0];
        w_div_is_rem  = r_funct3[1];
        w_op1_neg     = w_div_signed & r_op1[WIDTH-1];
        w_op2_neg     = w_div_signed & r_op2[WIDTH-1];
        w_op1_mag     = w_op1_neg ? (WIDTH'(0) - r_op1) : r_op1;
        w_op2_mag     = w_op2_neg ? (WIDTH'(0) - r_op2) : r_op2;
        w_div_zero    = (r_op2 == '0);
        w_div_ovf     = w_div_signed && (r_op1 == {1'b1, {(WIDTH-1){1'b0}}})
                        && (r_op2 == '1);
        w_div_special = w_div_zero | w_div_ovf;
        if (w_div_zero) begin
            w_special_res = w_div_is_rem ? r_op1 : '1;
        end else begin
            w_special_res = w_div_is_rem ? '0 : r_op1;
        end
        w_shift    = {r_rem, r_quot[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_dvs};
        w_rem_nxt  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_quot_nxt = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};
        w_div_last = (r_cnt == CNTW'(WIDTH-1));
        if (w_div_is_rem) begin
            w_div_res = r_neg_r ? (WIDTH'(0) - w_rem_nxt) : w_rem_nxt;
        end else begin
            w_div_res = r_neg_q ? (WIDTH'(0) - w_quot_nxt) : w_quot_nxt;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
`ifdef MULDIV_SHARE_DIV_EN
                    w_state_nxt = w_sel_f3[2] ? S_DIV : S_MUL;
`else
                    w_state_nxt = S_MUL;
`endif
                end
            end
            S_MUL: begin
                w_state_nxt = S_DONE;
            end
`ifdef MULDIV_SHARE_DIV_EN
            S_DIV: begin
                if (r_div_first) begin
                    if (w_div_special) begin
                        w_state_nxt = S_DONE;
                    end
                end else if (w_div_last) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (resp_ready[r_id]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request capture, result computation and response valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_funct3     <= '0;
            r_result     <= '0;
            r_resp_valid <= '0;
`ifdef MULDIV_SHARE_DIV_EN
            r_div_first  <= 1'b0;
            r_quot       <= '0;
            r_rem        <= '0;
            r_dvs        <= '0;
            r_cnt        <= '0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
`endif
        end else begin
            r_resp_valid <= (w_state_nxt == S_DONE) ? (NCORES'(1) << r_id) : '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id        <= w_winner;
                        r_op1       <= w_sel_op1;
                        r_op2       <= w_sel_op2;
                        r_funct3    <= w_sel_f3;
                        r_rr_ptr    <= w_ptr_nxt;
`ifdef MULDIV_SHARE_DIV_EN
                        r_div_first <= 1'b1;
`endif
                    end
                end
                S_MUL: begin
                    r_result <= w_mul_out;
                end
`ifdef MULDIV_SHARE_DIV_EN
                S_DIV: begin
                    if (r_div_first) begin
                        r_div_first <= 1'b0;
                        if (w_div_special) begin
                            r_result <= w_special_res;
                        end else begin
                            r_quot  <= w_op1_mag;
                            r_rem   <= '0;
                            r_dvs   <= w_op2_mag;
                            r_cnt   <= '0;
                            r_neg_q <= w_op1_neg ^ w_op2_neg;
                            r_neg_r <= w_op1_neg;
                        end
                    end else begin
                        r_quot <= w_quot_nxt;
                        r_rem  <= w_rem_nxt;
                        r_cnt  <= r_cnt + CNTW'(1);
                        if (w_div_last) begin
                            r_result <= w_div_res;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_result = r_result;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_muldiv_share_ctrl.sv
// Directed bench for muldiv_share_ctrl (WIDTH=32, NCORES=4).
module tb_muldiv_share_ctrl;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_op1;
    logic [N*W-1:0]   req_op2;
    logic [N*3-1:0]   req_funct3;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready;
    logic [W-1:0]     resp_result;
    logic             busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_share_ctrl #(.WIDTH(W), .NCORES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_funct3  (req_funct3),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    typedef struct {
        int         core;
        logic [W-1:0] op1;
        logic [W-1:0] op2;
        logic [2:0] f3;
        logic [W-1:0] exp;
        int         lat;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkv(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] f, input logic [W-1:0] e, input int l);
        vec_t v;
        v.core = c; v.op1 = a; v.op2 = b; v.f3 = f; v.exp = e; v.lat = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] f);
        req_op1[c*W +: W]  = a;
        req_op2[c*W +: W]  = b;
        req_funct3[c*3 +: 3] = f;
    endtask

    // One request from a single core, with grant, latency and result checks.
    task automatic run_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] f, input logic [W-1:0] e, input int lat,
                          input string nm);
        int n;
        @(negedge clk);
        set_req(c, a, b, f);
        req_valid = N'(1) << c;
        #1 chk({nm, " grant"}, 64'(req_ready), 64'(N'(1) << c));
        @(negedge clk);
        req_valid = '0;
        #1;
        n = 1;
        while (resp_valid == '0 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " resp_valid"}, 64'(resp_valid), 64'(N'(1) << c));
        chk({nm, " result"}, 64'(resp_result), 64'(e));
        chk({nm, " busy"}, 64'(busy), 64'(1));
        resp_ready = N'(1) << c;
        @(negedge clk);
        resp_ready = '0;
        #1;
        chk({nm, " idle busy"}, 64'(busy), 64'(0));
        chk({nm, " idle resp_valid"}, 64'(resp_valid), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_g[5];
        int g;
        exp_g = '{0, 1, 2, 3, 0};

        vt.push_back(mkv(0, 32'd7,        32'hFFFFFFFD, 3'b000, 32'hFFFFFFEB, 2));
        vt.push_back(mkv(1, 32'h80000000, 32'h80000000, 3'b001, 32'h40000000, 2));
        vt.push_back(mkv(2, 32'h80000000, 32'h80000000, 3'b011, 32'h40000000, 2));
        vt.push_back(mkv(3, 32'h80000000, 32'h80000000, 3'b010, 32'hC0000000, 2));
        vt.push_back(mkv(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 32'hFFFFFFFE, 2));
        vt.push_back(mkv(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 32'h00000001, 2));
        vt.push_back(mkv(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 32'h00000000, 2));
        vt.push_back(mkv(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 32'hFFFFFFFF, 2));
`ifdef MULDIV_SHARE_DIV_EN
        vt.push_back(mkv(0, 32'hFFFFFFF9, 32'd2,        3'b100, 32'hFFFFFFFD, W+2));
        vt.push_back(mkv(1, 32'hFFFFFFF9, 32'd2,        3'b110, 32'hFFFFFFFF, W+2));
        vt.push_back(mkv(2, 32'd5,        32'd0,        3'b101, 32'hFFFFFFFF, 2));
        vt.push_back(mkv(3, 32'd5,        32'd0,        3'b111, 32'd5,        2));
        vt.push_back(mkv(0, 32'h80000000, 32'hFFFFFFFF, 3'b100, 32'h80000000, 2));
        vt.push_back(mkv(1, 32'h80000000, 32'hFFFFFFFF, 3'b110, 32'd0,        2));
        vt.push_back(mkv(2, 32'd100,      32'd7,        3'b101, 32'd14,       W+2));
        vt.push_back(mkv(3, 32'd100,      32'd7,        3'b111, 32'd2,        W+2));
        vt.push_back(mkv(0, 32'd7,        32'hFFFFFFFE, 3'b100, 32'hFFFFFFFD, W+2));
        vt.push_back(mkv(1, 32'd7,        32'hFFFFFFFE, 3'b110, 32'd1,        W+2));
        vt.push_back(mkv(2, 32'hFFFFFFFF, 32'd3,        3'b101, 32'h55555555, W+2));
        vt.push_back(mkv(3, 32'h80000000, 32'hFFFFFFFF, 3'b111, 32'h80000000, W+2));
`else
        vt.push_back(mkv(0, 32'hFFFFFFF9, 32'd2,        3'b100, 32'd0, 2));
        vt.push_back(mkv(1, 32'd5,        32'd0,        3'b111, 32'd0, 2));
        vt.push_back(mkv(2, 32'h80000000, 32'hFFFFFFFF, 3'b110, 32'd0, 2));
        vt.push_back(mkv(3, 32'd100,      32'd7,        3'b101, 32'd0, 2));
`endif

        // Reset state.
        rst        = 1'b1;
        req_valid  = '0;
        req_op1    = '0;
        req_op2    = '0;
        req_funct3 = '0;
        resp_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset req_ready", 64'(req_ready), 64'(0));
        chk("reset resp_valid", 64'(resp_valid), 64'(0));
        chk("reset resp_result", 64'(resp_result), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        rst = 1'b0;

        // Round-robin: all cores request MULs, responses always accepted.
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int i = 0; i < int'(N); i++) set_req(i, W'(i + 1), 32'd10, 3'b000);
                req_valid  = '1;
                resp_ready = '1;
            end
            if (c == 13) req_valid = '0;
            #1;
            g = c / 3;
            if ((c % 3 == 0) && c <= 12)
                chk($sformatf("rr grant c%0d", c), 64'(req_ready), 64'(N'(1) << exp_g[g]));
            else
                chk($sformatf("rr no grant c%0d", c), 64'(req_ready), 64'(0));
            if ((c % 3 == 2) && c <= 14) begin
                chk($sformatf("rr resp_valid c%0d", c), 64'(resp_valid), 64'(N'(1) << exp_g[g]));
                chk($sformatf("rr result c%0d", c), 64'(resp_result), 64'(10 * (exp_g[g] + 1)));
            end else begin
                chk($sformatf("rr resp idle c%0d", c), 64'(resp_valid), 64'(0));
            end
        end
        resp_ready = '0;

        // Backpressure on core 2 (rr_ptr=1); other resp_ready bits high.
        @(negedge clk);
        set_req(2, 32'd6, 32'd7, 3'b000);
        req_valid  = 4'b0100;
        resp_ready = 4'b1011;
        #1 chk("bp grant", 64'(req_ready), 64'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("bp resp_valid", 64'(resp_valid), 64'(4'b0100));
        chk("bp result", 64'(resp_result), 64'(42));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                set_req(1, 32'd3, 32'd3, 3'b000);
                req_valid = 4'b0010;
            end
            #1;
            chk($sformatf("bp hold valid %0d", k), 64'(resp_valid), 64'(4'b0100));
            chk($sformatf("bp hold result %0d", k), 64'(resp_result), 64'(42));
            chk($sformatf("bp hold req_ready %0d", k), 64'(req_ready), 64'(0));
            chk($sformatf("bp hold busy %0d", k), 64'(busy), 64'(1));
        end
        @(negedge clk);
        resp_ready = 4'b0100;
        @(negedge clk);
        resp_ready = '0;
        #1;
        chk("bp released resp_valid", 64'(resp_valid), 64'(0));
        chk("bp next grant", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("bp core1 resp_valid", 64'(resp_valid), 64'(4'b0010));
        chk("bp core1 result", 64'(resp_result), 64'(9));
        resp_ready = 4'b0010;
        @(negedge clk);
        resp_ready = '0;
        #1 chk("bp core1 idle", 64'(busy), 64'(0));

        // Table-driven single-core operations.
        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i].core, vt[i].op1, vt[i].op2, vt[i].f3, vt[i].exp, vt[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Reset in the middle of a divide-class operation from core 1.
        @(negedge clk);
        set_req(1, 32'd100, 32'd7, 3'b100);
        req_valid = 4'b0010;
        #1 chk("mid grant", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1 chk("mid busy before rst", 64'(busy), 64'(1));
        @(negedge clk);
        #1;
        chk("mid rst busy", 64'(busy), 64'(0));
        chk("mid rst resp_valid", 64'(resp_valid), 64'(0));
        chk("mid rst result", 64'(resp_result), 64'(0));
        rst = 1'b0;
        run_op(3, 32'd3, 32'd5, 3'b000, 32'd15, 2, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
